rx_packet_deframer: RTL and testbench
=====================================

# rx_packet_deframer

- Single-clock block on the receive side of the crossbar. It sits directly downstream of the 8-entry async FIFO's read port.
- It drains show-ahead FIFO words, strips a one-word header, and presents the payload as a registered valid/ready stream.
- Each output beat carries start/end-of-packet markers and the destination ID taken from the header.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word and payload width; must be ≥ 16.

Ports:
- clk  in  1  receive-domain clock; the same clock as the FIFO's rx side.
- rst  in  1  reset; synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag (rx domain).
- fifo_data  in  DATA_WIDTH  FIFO head word; show-ahead, valid whenever !fifo_empty.
- fifo_pop  out  1  pops the FIFO head at this clk edge; combinational.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  payload word.
- out_sop  out  1  first payload beat of a packet.
- out_eop  out  1  last payload beat of a packet.
- out_dest  out  4  destination ID of the current packet.
- err_cnt  out  16  count of zero-length headers; present only with RX_DEFRAMER_ERR_CNT_EN.

## Operation
Header word format:
- length = fifo_data[7:0], payload beats 1..255.
- dest = fifo_data[11:8].
- Bits above 11 are ignored.

FSM states are HDR and PAYLOAD. Reset state is HDR.
- HDR, !fifo_empty:
  - Pop the header.
  - If length ≠ 0: latch dest into out_dest, load beat counter = length, set sop_pending, go to PAYLOAD.
  - If length = 0: discard the header, stay in HDR, increment err_cnt (if compiled in).
- PAYLOAD:
  - fifo_pop = !fifo_empty & (!out_valid | out_ready).
  - On a pop: the output register loads fifo_data; out_sop = sop_pending, then sop_pending clears; out_eop = (counter == 1); counter decrements.
  - Go to HDR on the pop where counter == 1.
- Output register:
  - out_valid sets on a payload pop.
  - out_valid clears on out_ready when no new pop occurs in the same cycle.
  - A pop while out_valid & out_ready replaces the beat back-to-back.
- Header pops never depend on out_ready. A pending last beat may still be held in the output register while the next header is consumed.
- Length 1: out_sop and out_eop are both high on the same beat.
- The beat counter is 8 bits and never wraps; it is only loaded with 1..255.
- out_dest holds its value until the next valid header.
- err_cnt saturates at 16'hFFFF.

## Timing
- Reset values: out_valid 0, out_data 0, out_sop 0, out_eop 0, out_dest 0, err_cnt 0, state HDR, counter 0.
- fifo_pop is 0 while rst is high.
- Latency:
  - Header popped at edge N.
  - First payload popped at edge N+1 at the earliest.
  - out_valid high after edge N+1.
- Throughput: 1 payload beat/cycle while out_ready is held high; 1 header-cycle bubble per packet.
- Handshake:
  - While out_valid & !out_ready, out_data/out_sop/out_eop/out_dest are stable and fifo_pop is 0 in PAYLOAD.
  - out_valid never drops without out_ready.
- FIFO empty mid-packet:
  - No pop; the state is held.
  - out_valid deasserts once the current beat is accepted.
  - The packet resumes when data arrives.
- Reset mid-packet returns the block to HDR and drops the held beat. Leftover FIFO payload words are parsed as headers; upstream reset must be coordinated.

## Configuration
- RX_DEFRAMER_ERR_CNT_EN defined: the err_cnt port and its 16-bit saturating counter exist.
- Undefined: the port and counter are absent. Zero-length headers are still silently discarded, with identical timing.

## Structure
- rx_deframer_pkg holds:
  - state enum {HDR, PAYLOAD};
  - header field constants LEN_LSB=0, LEN_W=8, DEST_LSB=8, DEST_W=4;
  - ERR_CNT_W=16.
- Sub-module rx_out_reg: the single-stage valid/ready output register (data + sop/eop/dest sideband), with the pop-enable term exported. The FSM and counter stay in the top level.

## Test plan
- Header 0x0000_0203 then payload A,B,C, out_ready=1 → out_dest=2; beats A(sop), B, C(eop) on consecutive cycles after a 1-cycle header bubble; state returns to HDR.
- Header length 1, payload 0xDEAD → a single beat with sop=eop=1; the next header is popped in the following cycle.
- Length-4 packet, out_ready low for 3 cycles on beat 2 → beat 2 is held stable, fifo_pop=0 throughout, no beat is lost or duplicated.
- Header 0x0000_0500 (length 0) followed by header 0x0000_0101 + payload → first header is discarded, err_cnt=1 (macro on), then one beat with dest=1.
- FIFO goes empty after 2 of 5 beats for 4 cycles → out_valid drops after beat 2 is accepted; the remaining 3 beats resume with correct eop.
- rst pulsed in the middle of a 4-beat packet → next cycle all outputs are at reset values, state HDR, err_cnt=0.

Source files
------------

// File: rtl/rx_packet_deframer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deframer_pkg
//  Description : Shared types and header-field constants for the rx deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_deframer_pkg;

    typedef enum logic [0:0] {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam int LEN_LSB   = 0;
    localparam int LEN_W     = 8;
    localparam int DEST_LSB  = 8;
    localparam int DEST_W    = 4;
    localparam int ERR_CNT_W = 16;

endpackage : rx_deframer_pkg
`default_nettype wire

// File: rtl/rx_packet_deframer_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_out_reg
//  Description : Single-stage valid/ready output register with sop/eop/dest
//                sideband; exports the term that allows a new beat to load.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_out_reg
    import rx_deframer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic [DEST_W-1:0]     dest_i,
    output logic                  load_en_o,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [DEST_W-1:0]     out_dest
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  sop_q,   sop_d;
    logic                  eop_q,   eop_d;
    logic [DEST_W-1:0]     dest_q,  dest_d;

    // A new beat may enter when the register is empty or being drained now.
    assign load_en_o = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        dest_d  = dest_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            sop_d   = sop_i;
            eop_d   = eop_i;
            dest_d  = dest_i;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            dest_q  <= dest_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_dest  = dest_q;

endmodule : rx_out_reg
`default_nettype wire

// File: rtl/rx_packet_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_packet_deframer
//  Description : Drains a show-ahead FIFO, strips the one-word header and
//                streams the payload with sop/eop/dest on a valid/ready port.
//                Define RX_DEFRAMER_ERR_CNT_EN to add the zero-length err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_deframer
    import rx_deframer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [DEST_W-1:0]     out_dest
`ifdef RX_DEFRAMER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

    state_t             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               sop_pending_q;
    logic [DEST_W-1:0]  dest_q;

    logic               w_load_en;
    logic               w_hdr_pop;
    logic               w_pay_pop;
    logic               w_last;
    logic [LEN_W-1:0]   w_len;

    assign w_len     = fifo_data[LEN_LSB +: LEN_W];
    assign w_last    = (cnt_q == LEN_W'(1));

    // Header pops ignore out_ready; payload pops wait for room in the output stage.
    assign w_hdr_pop = !rst && !fifo_empty && (state_q == HDR);
    assign w_pay_pop = !rst && !fifo_empty && (state_q == PAYLOAD) && w_load_en;
    assign fifo_pop  = w_hdr_pop || w_pay_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HDR;
            cnt_q         <= '0;
            sop_pending_q <= 1'b0;
            dest_q        <= '0;
        end else begin
            case (state_q)
                HDR: begin
                    if (w_hdr_pop && (w_len != '0)) begin
                        dest_q        <= fifo_data[DEST_LSB +: DEST_W];
                        cnt_q         <= w_len;
                        sop_pending_q <= 1'b1;
                        state_q       <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_pay_pop) begin
                        sop_pending_q <= 1'b0;
                        cnt_q         <= cnt_q - LEN_W'(1);
                        if (w_last) begin
                            state_q <= HDR;
                        end
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

    rx_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_pay_pop),
        .data_i    (fifo_data),
        .sop_i     (sop_pending_q),
        .eop_i     (w_last),
        .dest_i    (dest_q),
        .load_en_o (w_load_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_dest  (out_dest)
    );

`ifdef RX_DEFRAMER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (w_hdr_pop && (w_len == '0) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Zero-length headers are dropped by the HDR state without any record.
`endif

endmodule : rx_packet_deframer
`default_nettype wire

// File: tb/tb_rx_packet_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_packet_deframer
//  Description : Scoreboard bench for rx_packet_deframer with a show-ahead
//                FIFO model and directed packet vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_packet_deframer;

    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready  = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [3:0]    out_dest;
`ifdef RX_DEFRAMER_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            exp_err = 0;
    logic          hold    = 1'b0;
    logic          pop_pending = 1'b0;
    logic [DW-1:0] fifo_q[$];
    logic [DW+5:0] exp_q[$];   // {data, sop, eop, dest}
    logic [5:0]    pat;

    rx_packet_deframer #(
        .DATA_WIDTH (DW)
    ) dut (
`ifdef RX_DEFRAMER_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_dest   (out_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input logic [19:0] upper, input logic [3:0] dest, input logic [7:0] len);
        fifo_q.push_back({upper, dest, len});
    endtask

    task automatic push_body(input logic [3:0] dest, input int len, input logic [DW-1:0] base,
                             input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back({base + DW'(i), (i == 0), (i == len - 1), dest});
        end
    endtask

    task automatic push_pkt(input logic [3:0] dest, input int len, input logic [DW-1:0] base,
                            input logic [19:0] upper);
        push_hdr(upper, dest, 8'(len));
        push_body(dest, len, base, 0, len);
    endtask

    // Show-ahead FIFO model: pop decision sampled mid-cycle, head updated after the edge.
    always @(negedge clk) pop_pending = fifo_pop;

    always begin
        @(posedge clk);
        if (pop_pending) begin
            chk("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        #2;
        fifo_empty = hold || (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // Monitor: every accepted beat is checked against the scoreboard queue.
    logic          held_v = 1'b0;
    logic [DW+5:0] held;
    logic [DW+5:0] got;
    logic [DW+5:0] e;

    always @(negedge clk) begin
        got = {out_data, out_sop, out_eop, out_dest};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold_stable", {got, out_valid}, {held, 1'b1});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {got, 1'b1}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", got, e);
                end
            end
            held_v = out_valid && !out_ready;
            held   = got;
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_sop",   out_sop,   0);
        chk("rst_eop",   out_eop,   0);
        chk("rst_dest",  out_dest,  0);
        chk("rst_pop",   fifo_pop,  0);
`ifdef RX_DEFRAMER_ERR_CNT_EN
        chk("rst_err", err_cnt, 0);
`endif
        step(1);
        rst = 1'b0;
        step(2);

        // Three-beat packet to dest 2: header bubble then A,B,C back to back.
        hold = 1'b1;
        push_pkt(4'h2, 3, 32'hA000_0000, 20'h0);
        step(1);
        hold = 1'b0;
        pat = 6'b011100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_valid_seq", out_valid, pat[i]);
        end
        step(2);

        // Single-beat packet, next header must pop on the very next cycle.
        hold = 1'b1;
        push_pkt(4'hE, 1, 32'h0000_DEAD, 20'h0);
        push_pkt(4'h7, 2, 32'hC000_0000, 20'h0);
        step(1);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_pop_seq", fifo_pop, 1);
        end
        step(6);

        // Backpressure on beat 2 of a 4-beat packet for three cycles.
        hold = 1'b1;
        push_pkt(4'h3, 4, 32'h3000_0000, 20'h0);
        step(1);
        hold = 1'b0;
        step(3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_no_pop", fifo_pop,  0);
            chk("t3_valid",  out_valid, 1);
            chk("t3_data",   out_data,  32'h3000_0001);
            step(1);
        end
        out_ready = 1'b1;
        step(6);

        // Zero-length header is dropped, following one-beat packet to dest 1.
        push_hdr(20'h0, 4'h5, 8'd0);
        exp_err++;
        push_pkt(4'h1, 1, 32'h0000_BEEF, 20'h0);
        step(8);
`ifdef RX_DEFRAMER_ERR_CNT_EN
        chk("t4_err_cnt", err_cnt, 64'(exp_err));
`endif

        // FIFO runs dry after two of five beats, then resumes.
        push_hdr(20'h0, 4'h5, 8'd5);
        push_body(4'h5, 5, 32'h5000_0000, 0, 2);
        step(4);
        @(negedge clk);
        chk("t5_valid_drop", out_valid, 0);
        step(3);
        push_body(4'h5, 5, 32'h5000_0000, 2, 5);
        step(10);

        // Reset in the middle of a 4-beat packet.
        hold = 1'b1;
        push_pkt(4'h9, 4, 32'h9000_0000, 20'h0);
        step(1);
        hold = 1'b0;
        step(2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_pop_in_rst", fifo_pop, 0);
        step(1);
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_data",  out_data,  0);
        chk("t6_sop",   out_sop,   0);
        chk("t6_eop",   out_eop,   0);
        chk("t6_dest",  out_dest,  0);
`ifdef RX_DEFRAMER_ERR_CNT_EN
        chk("t6_err", err_cnt, 0);
`endif
        step(1);

        // After reset: header with junk in the ignored upper bits.
        push_pkt(4'hF, 2, 32'h7000_0000, 20'hFFFFF);
        step(6);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rx_packet_deframer
`default_nettype wire
